// File: rtl/eth_phy_10g_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : eth_phy_10g_rx_sync
// Purpose  : Per-lane 64b/66b block lock, bitslip control, BER monitor,
//            SERDES reset request and aggregate link status.
// Option   : ETH_PHY_RX_SYNC_ERR_CNT_EN adds per-window invalid-header counters.
// Revision : 1.0
// ============================================================================
module eth_phy_10g_rx_sync #(
    parameter int LANES               = 1,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int COUNT_125US         = 19531,
    parameter int RESET_WINDOWS       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*LANES-1:0]   serdes_rx_hdr,
    input  logic [LANES-1:0]     serdes_rx_hdr_valid,
    output logic [LANES-1:0]     serdes_rx_bitslip,
    output logic [LANES-1:0]     serdes_rx_reset_req,
    output logic [LANES-1:0]     rx_block_lock,
    output logic [LANES-1:0]     rx_high_ber,
    output logic [7*LANES-1:0]   rx_error_count,
    output logic                 rx_status
);

    localparam int c_TMR_W = $clog2(COUNT_125US + 1);
    localparam int c_SLP_W = $clog2(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES + 1);
    localparam int c_WIN_W = $clog2(RESET_WINDOWS + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(COUNT_125US - 1);
    localparam logic [c_SLP_W-1:0] c_SLP_HIGH = c_SLP_W'(BITSLIP_HIGH_CYCLES);
    localparam logic [c_SLP_W-1:0] c_SLP_LAST =
        c_SLP_W'(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES - 1);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(RESET_WINDOWS - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SLIP     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    logic [c_TMR_W-1:0] r_timer;
    logic               w_tick;
    logic               w_all_good;
    logic               r_status;
    logic               r_win_ok;

    assign w_tick = (r_timer == c_TMR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + c_TMR_W'(1);
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        state_t             r_state, w_state_nx;
        logic [5:0]         r_sh_cnt, w_sh_cnt_nx;
        logic [4:0]         r_sh_inv, w_sh_inv_nx;
        logic [c_SLP_W-1:0] r_slip_cnt, w_slip_cnt_nx;
        logic               r_lock, w_lock_nx;
        logic               r_slip, w_slip_nx;
        logic [4:0]         r_ber, w_ber_inc, w_ber_nx;
        logic               r_hber, w_hber_nx;
        logic [c_WIN_W-1:0] r_win, w_win_nx;
        logic [1:0]         w_hdr;
        logic               w_hv;
        logic               w_hdr_ok;
        logic               w_bad;

        assign w_hdr    = serdes_rx_hdr[2*n +: 2];
        assign w_hv     = serdes_rx_hdr_valid[n];
        assign w_hdr_ok = w_hdr[1] ^ w_hdr[0];

        always_comb begin
            w_state_nx    = r_state;
            w_sh_cnt_nx   = r_sh_cnt;
            w_sh_inv_nx   = r_sh_inv;
            w_slip_cnt_nx = r_slip_cnt;
            w_lock_nx     = r_lock;
            w_slip_nx     = 1'b0;
            w_bad         = 1'b0;
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_hv) begin
                        if (w_hdr_ok) begin
                            if (r_sh_cnt == 6'd63) begin
                                w_state_nx  = ST_LOCKED;
                                w_lock_nx   = 1'b1;
                                w_sh_cnt_nx = '0;
                                w_sh_inv_nx = '0;
                            end else begin
                                w_sh_cnt_nx = r_sh_cnt + 6'd1;
                            end
                        end else begin
                            w_state_nx    = ST_SLIP;
                            w_sh_cnt_nx   = '0;
                            w_sh_inv_nx   = '0;
                            w_slip_cnt_nx = '0;
                            w_slip_nx     = 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    // Slip pulse first, then blanking so the gearbox settles
                    w_slip_cnt_nx = r_slip_cnt + c_SLP_W'(1);
                    w_slip_nx     = (r_slip_cnt + c_SLP_W'(1)) < c_SLP_HIGH;
                    if (r_slip_cnt == c_SLP_LAST) begin
                        w_state_nx    = ST_UNLOCKED;
                        w_slip_cnt_nx = '0;
                        w_slip_nx     = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (w_hv) begin
                        w_sh_cnt_nx = r_sh_cnt + 6'd1;
                        if (!w_hdr_ok) begin
                            w_bad       = 1'b1;
                            w_sh_inv_nx = r_sh_inv + 5'd1;
                        end
                        if (!w_hdr_ok && (r_sh_inv == 5'd15)) begin
                            w_state_nx    = ST_SLIP;
                            w_lock_nx     = 1'b0;
                            w_sh_cnt_nx   = '0;
                            w_sh_inv_nx   = '0;
                            w_slip_cnt_nx = '0;
                            w_slip_nx     = 1'b1;
                        end else if (r_sh_cnt == 6'd63) begin
                            w_sh_cnt_nx = '0;
                            w_sh_inv_nx = '0;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_UNLOCKED;
                end
            endcase
        end

        // BER count saturates at 16 so "reached 16" stays visible until the tick
        always_comb begin
            w_ber_inc = (w_bad && (r_ber != 5'd16)) ? r_ber + 5'd1 : r_ber;
            w_hber_nx = r_hber | (w_ber_inc == 5'd16);
            w_ber_nx  = w_ber_inc;
            w_win_nx  = r_win;
            if (w_tick) begin
                w_hber_nx = (w_ber_inc == 5'd16);
                w_ber_nx  = '0;
                w_win_nx  = (r_lock || (r_win == c_WIN_LAST)) ? '0 : r_win + c_WIN_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_UNLOCKED;
                r_sh_cnt   <= '0;
                r_sh_inv   <= '0;
                r_slip_cnt <= '0;
                r_lock     <= 1'b0;
                r_slip     <= 1'b0;
                r_ber      <= '0;
                r_hber     <= 1'b0;
                r_win      <= '0;
            end else begin
                r_state    <= w_state_nx;
                r_sh_cnt   <= w_sh_cnt_nx;
                r_sh_inv   <= w_sh_inv_nx;
                r_slip_cnt <= w_slip_cnt_nx;
                r_lock     <= w_lock_nx;
                r_slip     <= w_slip_nx;
                r_ber      <= w_ber_nx;
                r_hber     <= w_hber_nx;
                r_win      <= w_win_nx;
            end
        end

        assign serdes_rx_bitslip[n]   = r_slip;
        assign rx_block_lock[n]       = r_lock;
        assign rx_high_ber[n]         = r_hber;
        assign serdes_rx_reset_req[n] = w_tick && !r_lock && (r_win == c_WIN_LAST);

`ifdef ETH_PHY_RX_SYNC_ERR_CNT_EN
        logic [6:0] r_err, w_err_inc, r_err_out;

        assign w_err_inc = (w_bad && (r_err != 7'd127)) ? r_err + 7'd1 : r_err;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_err     <= '0;
                r_err_out <= '0;
            end else if (w_tick) begin
                r_err     <= '0;
                r_err_out <= w_err_inc;
            end else begin
                r_err     <= w_err_inc;
            end
        end

        assign rx_error_count[7*n +: 7] = r_err_out;
`else
        assign rx_error_count[7*n +: 7] = 7'd0;
`endif
    end

    assign w_all_good = &(rx_block_lock & ~rx_high_ber);

    // r_win_ok remembers whether every cycle since the last tick was clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 1'b0;
            r_win_ok <= 1'b0;
        end else begin
            if (!w_all_good) begin
                r_status <= 1'b0;
            end else if (w_tick) begin
                r_status <= r_win_ok;
            end
            r_win_ok <= w_tick ? 1'b1 : (r_win_ok & w_all_good);
        end
    end

    assign rx_status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_eth_phy_10g_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_phy_10g_rx_sync
// Purpose  : Self-checking bench for eth_phy_10g_rx_sync (2 lanes, 100-cycle window).
// Revision : 1.0
// ============================================================================
module tb_eth_phy_10g_rx_sync;

    localparam int LANES = 2;
    localparam int HI    = 1;
    localparam int LO    = 8;
    localparam int CNT   = 100;
    localparam int RW    = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [2*LANES-1:0]   hdr = '0;
    logic [LANES-1:0]     hv = '0;
    logic [LANES-1:0]     serdes_rx_bitslip;
    logic [LANES-1:0]     serdes_rx_reset_req;
    logic [LANES-1:0]     rx_block_lock;
    logic [LANES-1:0]     rx_high_ber;
    logic [7*LANES-1:0]   rx_error_count;
    logic                 rx_status;

    eth_phy_10g_rx_sync #(
        .LANES               (LANES),
        .BITSLIP_HIGH_CYCLES (HI),
        .BITSLIP_LOW_CYCLES  (LO),
        .COUNT_125US         (CNT),
        .RESET_WINDOWS       (RW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .serdes_rx_hdr       (hdr),
        .serdes_rx_hdr_valid (hv),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .rx_block_lock       (rx_block_lock),
        .rx_high_ber         (rx_high_ber),
        .rx_error_count      (rx_error_count),
        .rx_status           (rx_status)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counts of headers, remaining slip cycles, window counters
    int m_timer;
    int m_run[LANES], m_slip[LANES], m_grp[LANES], m_gbad[LANES];
    int m_ber[LANES], m_err[LANES], m_errout[LANES], m_win[LANES];
    bit m_lock[LANES], m_hber[LANES];
    bit m_status, m_winok;
    int rreq_cnt[LANES];
    int rreq_first;
    int cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_timer  = 0;
        m_status = 1'b0;
        m_winok  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            m_run[l] = 0; m_slip[l] = 0; m_grp[l] = 0; m_gbad[l] = 0;
            m_ber[l] = 0; m_err[l] = 0; m_errout[l] = 0; m_win[l] = 0;
            m_lock[l] = 1'b0; m_hber[l] = 1'b0;
        end
    endtask

    function automatic logic [LANES-1:0] exp_rreq();
        logic [LANES-1:0] r;
        for (int l = 0; l < LANES; l++)
            r[l] = (m_timer == CNT - 1) && !m_lock[l] && (m_win[l] == RW - 1);
        return r;
    endfunction

    task automatic m_step(input logic [2*LANES-1:0] h, input logic [LANES-1:0] v);
        bit t, all_good, ok, bad, was_locked;
        logic [1:0] hl;
        t = (m_timer == CNT - 1);
        all_good = 1'b1;
        for (int l = 0; l < LANES; l++)
            if (!m_lock[l] || m_hber[l]) all_good = 1'b0;
        if (!all_good)  m_status = 1'b0;
        else if (t)     m_status = m_winok;
        m_winok = t ? 1'b1 : (m_winok & all_good);
        for (int l = 0; l < LANES; l++) begin
            hl = h[2*l +: 2];
            ok = v[l] && (hl == 2'b01 || hl == 2'b10);
            bad = v[l] && !(hl == 2'b01 || hl == 2'b10);
            was_locked = m_lock[l];
            if (t) m_win[l] = (was_locked || m_win[l] == RW - 1) ? 0 : m_win[l] + 1;
            if (m_slip[l] > 0) begin
                m_slip[l]--;
            end else if (!m_lock[l]) begin
                if (ok) begin
                    m_run[l]++;
                    if (m_run[l] == 64) begin
                        m_lock[l] = 1'b1; m_run[l] = 0; m_grp[l] = 0; m_gbad[l] = 0;
                    end
                end else if (bad) begin
                    m_run[l] = 0;
                    m_slip[l] = HI + LO;
                end
            end else if (v[l]) begin
                m_grp[l]++;
                if (bad) begin
                    m_gbad[l]++;
                    if (m_ber[l] < 16)  m_ber[l]++;
                    if (m_err[l] < 127) m_err[l]++;
                end
                if (m_gbad[l] == 16) begin
                    m_lock[l] = 1'b0; m_slip[l] = HI + LO;
                    m_grp[l] = 0; m_gbad[l] = 0; m_run[l] = 0;
                end else if (m_grp[l] == 64) begin
                    m_grp[l] = 0; m_gbad[l] = 0;
                end
            end
            if (t) begin
                m_hber[l] = (m_ber[l] >= 16);
                m_errout[l] = m_err[l];
                m_ber[l] = 0;
                m_err[l] = 0;
            end else if (m_ber[l] >= 16) begin
                m_hber[l] = 1'b1;
            end
        end
        m_timer = t ? 0 : m_timer + 1;
    endtask

    task automatic check_outputs();
        logic [LANES-1:0]   el, es, eh;
        logic [7*LANES-1:0] ee;
        for (int l = 0; l < LANES; l++) begin
            el[l] = m_lock[l];
            es[l] = (m_slip[l] > LO);
            eh[l] = m_hber[l];
`ifdef ETH_PHY_RX_SYNC_ERR_CNT_EN
            ee[7*l +: 7] = 7'(m_errout[l]);
`else
            ee[7*l +: 7] = 7'd0;
`endif
        end
        check("block_lock", rx_block_lock, el);
        check("bitslip", serdes_rx_bitslip, es);
        check("high_ber", rx_high_ber, eh);
        check("error_count", rx_error_count, ee);
        check("status", rx_status, m_status);
    endtask

    task automatic cycle(input logic [2*LANES-1:0] h, input logic [LANES-1:0] v);
        logic [LANES-1:0] er;
        hdr = h;
        hv  = v;
        er  = exp_rreq();
        check("reset_req", serdes_rx_reset_req, er);
        for (int l = 0; l < LANES; l++) begin
            if (serdes_rx_reset_req[l]) begin
                if (l == 0 && rreq_cnt[0] == 0) rreq_first = cyc;
                rreq_cnt[l]++;
            end
        end
        m_step(h, v);
        cyc++;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n, input logic [2*LANES-1:0] h);
        for (int i = 0; i < n; i++) cycle(h, 2'b11);
    endtask

    task automatic apply_reset();
        hdr = '0;
        hv  = '0;
        rst_n = 1'b0;
        #1;
        m_reset();
        cyc = 0;
        rreq_first = -1;
        for (int l = 0; l < LANES; l++) rreq_cnt[l] = 0;
        check_outputs();
        check("reset_req_rst", serdes_rx_reset_req, '0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         reps;
        logic [1:0] h0;
        logic [1:0] h1;
        logic       exp_lock;
        logic       exp_slip;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{63, 2'b01, 2'b10, 1'b0, 1'b0};
        tbl[1]  = '{1,  2'b00, 2'b10, 1'b0, 1'b1};
        tbl[2]  = '{1,  2'b01, 2'b10, 1'b0, 1'b0};
        tbl[3]  = '{7,  2'b01, 2'b10, 1'b0, 1'b0};
        tbl[4]  = '{1,  2'b11, 2'b10, 1'b0, 1'b0};
        tbl[5]  = '{63, 2'b10, 2'b10, 1'b0, 1'b0};
        tbl[6]  = '{1,  2'b01, 2'b10, 1'b1, 1'b0};
        tbl[7]  = '{15, 2'b00, 2'b10, 1'b1, 1'b0};
        tbl[8]  = '{49, 2'b01, 2'b10, 1'b1, 1'b0};
        tbl[9]  = '{15, 2'b11, 2'b10, 1'b1, 1'b0};
        tbl[10] = '{49, 2'b10, 2'b10, 1'b1, 1'b0};
        tbl[11] = '{15, 2'b00, 2'b10, 1'b1, 1'b0};
        tbl[12] = '{1,  2'b00, 2'b10, 1'b0, 1'b1};
        tbl[13] = '{9,  2'b01, 2'b10, 1'b0, 1'b0};

        #3;
        apply_reset();

        // Lock acquisition, slip timing and in-lock error tolerance on lane 0
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < tbl[i].reps; k++) cycle({tbl[i].h1, tbl[i].h0}, 2'b11);
            check($sformatf("tbl%0d_lock", i), rx_block_lock[0], tbl[i].exp_lock);
            check($sformatf("tbl%0d_slip", i), serdes_rx_bitslip[0], tbl[i].exp_slip);
        end

        // High BER, error count and link status across windows
        apply_reset();
        run(64, 4'b1001);
        check("both_locked", rx_block_lock, 2'b11);
        for (int i = 0; i < 2 * CNT && m_timer != 0; i++) cycle(4'b1001, 2'b11);
        run(8, 4'b1000);
        run(56, 4'b1001);
        run(8, 4'b1000);
        check("hber_mid_window", rx_high_ber, 2'b01);
        check("lock_with_hber", rx_block_lock, 2'b11);
        run(28, 4'b1001);
        check("hber_after_tick", rx_high_ber, 2'b01);
`ifdef ETH_PHY_RX_SYNC_ERR_CNT_EN
        check("err_count_16", rx_error_count, 14'd16);
`else
        check("err_count_off", rx_error_count, 14'd0);
`endif
        check("status_bad_window", rx_status, 1'b0);
        run(CNT, 4'b1001);
        check("hber_cleared", rx_high_ber, 2'b00);
        check("status_still_low", rx_status, 1'b0);
        check("err_count_clean", rx_error_count, 14'd0);
        run(CNT, 4'b1001);
        check("status_up", rx_status, 1'b1);
        run(16, 4'b0001);
        check("lane1_dropped", rx_block_lock, 2'b01);
        check("status_before_fall", rx_status, 1'b1);
        run(1, 4'b1001);
        check("status_fell", rx_status, 1'b0);

        // Asynchronous reset while locked with high BER, then relock
        run(8, 4'b1000);
        run(56, 4'b1001);
        run(8, 4'b1000);
        check("pre_rst_hber", rx_high_ber[0], 1'b1);
        check("pre_rst_lock", rx_block_lock[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_lock", rx_block_lock, 2'b00);
        check("async_hber", rx_high_ber, 2'b00);
        check("async_status", rx_status, 1'b0);
        check("async_errcnt", rx_error_count, 14'd0);
        check("async_slip", serdes_rx_bitslip, 2'b00);
        apply_reset();
        run(63, 4'b1001);
        check("relock_63", rx_block_lock, 2'b00);
        run(1, 4'b1001);
        check("relock_64", rx_block_lock, 2'b11);

        // Reset during a slip aborts it
        apply_reset();
        run(1, 4'b1000);
        check("slip_started", serdes_rx_bitslip, 2'b01);
        #1;
        rst_n = 1'b0;
        #1;
        check("slip_aborted", serdes_rx_bitslip, 2'b00);
        apply_reset();

        // SERDES reset request after RESET_WINDOWS unlocked ticks
        run(8 * CNT, 4'b1000);
        check("rreq_lane0_count", rreq_cnt[0], 2);
        check("rreq_lane1_count", rreq_cnt[1], 0);
        check("rreq_first_cycle", rreq_first, RW * CNT - 1);

        // Randomized traffic with varying error density
        apply_reset();
        for (int seg = 0; seg < 16; seg++) begin
            int rate;
            logic [2*LANES-1:0] h;
            logic [LANES-1:0]   v;
            case (seg % 4)
                0: rate = 0;
                1: rate = 3;
                2: rate = 40;
                default: rate = 300;
            endcase
            if (seg == 8) apply_reset();
            for (int c = 0; c < 200; c++) begin
                for (int l = 0; l < LANES; l++) begin
                    v[l] = ($urandom_range(0, 9) != 0);
                    if ($urandom_range(0, 999) < rate)
                        h[2*l +: 2] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                    else
                        h[2*l +: 2] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
                end
                cycle(h, v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
